// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmitter, the receiver and their benches:
//   tx_state_t      - transmitter FSM state encoding
//   PAR_NONE/EVEN/ODD - parity-mode codes
//   uart_frame_len()  - clock cycles occupied by one complete frame
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  // Cycles from the first start-bit cycle to the last stop-bit cycle inclusive.
  function automatic int unsigned uart_frame_len(
    input int unsigned data_bits,
    input logic [1:0]  parity_mode,
    input int unsigned stop_bits,
    input int unsigned clks_per_bit
  );
    int unsigned par_bits;
    par_bits = (parity_mode == PAR_NONE) ? 0 : 1;
    return (1 + data_bits + par_bits + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Loadable bit-period down-counter. A pulse on load starts a new bit period of
// exactly CLKS_PER_BIT cycles; bit_end is high on the last cycle of the period.
// Ports:
//   clk      in  clock, rising edge
//   arst     in  asynchronous active-high reset
//   rst      in  synchronous active-high clear
//   load     in  start a new bit period on this edge
//   bit_end  out current cycle is the last of the bit period (count == 0)
// -----------------------------------------------------------------------------
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 10417
) (
  input  logic clk,
  input  logic arst,
  input  logic rst,
  input  logic load,
  output logic bit_end
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (rst) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_param.sv
// -----------------------------------------------------------------------------
// uart_tx_param
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB-first,
// optional even/odd parity, 1 or 2 stop bits. A one-entry holding buffer lets
// the next word wait while a frame is on the line, so frames run back-to-back.
// Ports:
//   clk       in  clock, rising edge
//   arst      in  asynchronous active-high reset
//   rst       in  synchronous active-high clear (same effect as arst)
//   tx_data   in  word to send, sampled on transfer
//   tx_valid  in  producer has a word
//   tx_ready  out holding buffer empty (transfer = tx_valid && tx_ready)
//   tx        out registered serial line, idle high
//   busy      out frame on the line or holding buffer full
//   done      out one-cycle pulse in the cycle after the last stop bit
// -----------------------------------------------------------------------------
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 10417,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned       IDX_W       = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(DATA_BITS - 1);
  localparam logic              LAST_STOP   = (STOP_BITS == 2) ? 1'b1 : 1'b0;
  localparam logic              PAR_ODD_BIT = (PARITY_ODD != 0) ? 1'b1 : 1'b0;
  localparam bit                HAS_PARITY  = (PARITY_EN != 0);

  tx_state_t            state_q,     state_d;
  logic [DATA_BITS-1:0] shift_q,     shift_d;
  logic                 par_q,       par_d;
  logic [IDX_W-1:0]     bit_idx_q,   bit_idx_d;
  logic                 stop_idx_q,  stop_idx_d;
  logic [DATA_BITS-1:0] hold_data_q, hold_data_d;
  logic                 hold_full_q, hold_full_d;
  logic                 tx_q,        tx_d;
  logic                 done_q,      done_d;

  logic pull;
  logic transfer;
  logic bit_end;
  logic baud_load;

  assign tx_ready = ~hold_full_q & ~rst;
  assign transfer = tx_valid & tx_ready;

  // NOTE: every signal written in this block gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    par_d       = par_q;
    bit_idx_d   = bit_idx_q;
    stop_idx_d  = stop_idx_q;
    hold_data_d = hold_data_q;
    hold_full_d = hold_full_q;
    done_d      = 1'b0;
    pull        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (hold_full_q) pull = 1'b1;
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + IDX_W'(1);
          if (bit_idx_q == LAST_IDX) begin
            bit_idx_d = '0;
            state_d   = HAS_PARITY ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (stop_idx_q == LAST_STOP) begin
            stop_idx_d = 1'b0;
            done_d     = 1'b1;
            // Pulling here, on the final stop-bit cycle, is what gives
            // back-to-back frames with no idle gap.
            if (hold_full_q) pull = 1'b1;
            else             state_d = IDLE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pull) begin
      state_d     = START;
      shift_d     = hold_data_q;
      par_d       = (^hold_data_q) ^ PAR_ODD_BIT;
      hold_full_d = 1'b0;
    end

    // A transfer in the same cycle as a pull refills the buffer; the pull
    // above already took the old word from hold_data_q.
    if (transfer) begin
      hold_full_d = 1'b1;
      hold_data_d = tx_data;
    end

    if (rst) begin
      state_d     = IDLE;
      shift_d     = '0;
      par_d       = 1'b0;
      bit_idx_d   = '0;
      stop_idx_d  = 1'b0;
      hold_data_d = '0;
      hold_full_d = 1'b0;
      done_d      = 1'b0;
    end

    // tx is registered from the next state so the line level changes on the
    // same edge as the state.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  // A new bit period begins on a pull from IDLE or whenever a bit ends and
  // the FSM stays active.
  always_comb begin
    if (state_q == IDLE) baud_load = pull & ~rst;
    else                 baud_load = bit_end & (state_d != IDLE);
  end

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .arst    (arst),
    .rst     (rst),
    .load    (baud_load),
    .bit_end (bit_end)
  );

  // NOTE: the datapath registers are reset along with the control flops; they
  // are few, and it keeps every output defined straight out of reset.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      par_q       <= 1'b0;
      bit_idx_q   <= '0;
      stop_idx_q  <= 1'b0;
      hold_data_q <= '0;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      bit_idx_q   <= bit_idx_d;
      stop_idx_q  <= stop_idx_d;
      hold_data_q <= hold_data_d;
      hold_full_q <= hold_full_d;
      tx_q        <= tx_d;
      done_q      <= done_d;
    end
  end

  assign tx   = tx_q;
  assign done = done_q;
  assign busy = (state_q != IDLE) | hold_full_q;

endmodule
